// File: rtl/proc_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encoding and
// memory depth derived from the address width.
package proc_pkg;

   localparam int ADDR_W_DEF = 8;

   function automatic int depth_of(input int aw);
      return 2 ** aw;
   endfunction

   localparam int DEPTH = depth_of(ADDR_W_DEF);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_FLUSH,
      ST_RUN,
      ST_HALT
   } state_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; a synchronous clear wins over enable.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr_i,
   input  logic         en_i,
   output logic [W-1:0] count_o
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (en_i && (count_q != {W{1'b1}})) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/imem_loader.sv
// Streams a host-supplied program into instruction memory, then releases the
// core for an optional cycle budget and reports completion.
module imem_loader
   import proc_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              host_start,
   input  logic [ADDR_W:0]   host_len,
   input  logic [15:0]       run_cycles,
   input  logic              host_valid,
   input  logic [DATA_W-1:0] host_data,
   output logic              host_ready,
   output logic              im_we,
   output logic [ADDR_W-1:0] im_addr,
   output logic [DATA_W-1:0] im_wdata,
   output logic              core_ready,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [15:0]       cycle_count
);

   localparam int              DEPTH_L = depth_of(ADDR_W);
   localparam logic [ADDR_W:0] DEPTH_V = DEPTH_L[ADDR_W:0];

   state_t              state_q, state_d;
   logic [ADDR_W:0]     len_q, len_d;
   logic [15:0]         budget_q, budget_d;
   logic [ADDR_W-1:0]   idx_q, idx_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                err_q, err_d;

   logic                cmd_ok;
   logic                start_ok;
   logic                last_word;
   logic                cnt_clr;
   logic                cnt_en;

   assign cmd_ok    = (host_len != '0) && (host_len <= DEPTH_V);
   assign start_ok  = host_start && cmd_ok &&
                      ((state_q == ST_IDLE) || (state_q == ST_RUN) || (state_q == ST_HALT));
   assign last_word = ({1'b0, idx_q} == (len_q - 1'b1));

   always_comb begin
      state_d  = state_q;
      len_d    = len_q;
      budget_d = budget_q;
      idx_d    = idx_q;
      we_d     = 1'b0;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      err_d    = host_start && !start_ok;
      cnt_clr  = 1'b0;
      cnt_en   = 1'b0;

      case (state_q)
         ST_IDLE: begin
         end
         ST_LOAD: begin
            if (host_valid) begin
               we_d    = 1'b1;
               addr_d  = idx_q;
               wdata_d = host_data;
               // Index stops on the final word so it can never pass DEPTH-1.
               if (last_word) begin
                  state_d = ST_FLUSH;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         ST_FLUSH: begin
            state_d = ST_RUN;
         end
         ST_RUN: begin
            cnt_en = 1'b1;
            if ((budget_q != '0) && (cycle_count == (budget_q - 1'b1))) begin
               state_d = ST_HALT;
            end
         end
         ST_HALT: begin
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // A fresh session overrides whatever RUN/HALT would have done this cycle.
      if (start_ok) begin
         len_d    = host_len;
         budget_d = run_cycles;
         idx_d    = '0;
         cnt_clr  = 1'b1;
         state_d  = ST_LOAD;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         len_q    <= '0;
         budget_q <= '0;
         idx_q    <= '0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         len_q    <= len_d;
         budget_q <= budget_d;
         idx_q    <= idx_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         err_q    <= err_d;
      end
   end

   sat_counter #(
      .W (16)
   ) u_cnt (
      .clk     (clk),
      .rst     (rst),
      .clr_i   (cnt_clr),
      .en_i    (cnt_en),
      .count_o (cycle_count)
   );

   assign host_ready = (state_q == ST_LOAD);
   assign core_ready = (state_q == ST_RUN);
   assign busy       = (state_q == ST_LOAD) || (state_q == ST_FLUSH) || (state_q == ST_RUN);
   assign done       = (state_q == ST_HALT);
   assign err        = err_q;
   assign im_we      = we_q;
   assign im_addr    = addr_q;
   assign im_wdata   = wdata_q;

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter ADDR_W, default 8, instruction memory address width; depth DEPTH = 2^ADDR_W.
REQ-002 Parameter DATA_W, default 16, instruction word width.
REQ-003 clk  input  1  single system clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 host_start  input  1  one-cycle pulse requesting a new load session.
REQ-006 host_len  input  ADDR_W+1  word count for the session; sampled with host_start.
REQ-007 run_cycles  input  16  run budget in cycles; 0 = unlimited; sampled with host_start.
REQ-008 host_valid  input  1  host word valid.
REQ-009 host_data  input  DATA_W  host instruction word.
REQ-010 host_ready  output  1  loader accepts a word this cycle.
REQ-011 im_we  output  1  instruction memory write strobe.
REQ-012 im_addr  output  ADDR_W  instruction memory write address.
REQ-013 im_wdata  output  DATA_W  instruction memory write data.
REQ-014 core_ready  output  1  drives the processor ready input; high only while running.
REQ-015 busy  output  1  high in LOAD, FLUSH, RUN.
REQ-016 done  output  1  high in HALT.
REQ-017 err  output  1  one-cycle pulse on rejected command.
REQ-018 cycle_count  output  16  cycles spent in RUN for the current session.

Function
REQ-019 States SHALL be IDLE, LOAD, FLUSH, RUN, HALT.
REQ-020 IDLE: host_ready=0, core_ready=0; host_start with 1<=host_len<=DEPTH -> latch len/budget, word index=0, go LOAD.
REQ-021 host_start with host_len==0 or host_len>DEPTH -> err pulse next cycle, state unchanged.
REQ-022 LOAD: host_ready=1; a word transfers when host_valid&&host_ready.
REQ-023 Each transfer SHALL produce im_we=1 with im_addr=index, im_wdata=host_data exactly one cycle later (registered outputs); im_we=0 otherwise.
REQ-024 Index increments per transfer; transfer of word len-1 -> FLUSH; host_ready=0 from the following cycle.
REQ-025 FLUSH: one cycle, lets the final write land; then RUN.
REQ-026 RUN: core_ready=1; cycle_count increments each RUN cycle starting at 0; saturates at 16'hFFFF.
REQ-027 run_cycles!=0: after exactly run_cycles RUN cycles -> HALT; cycle_count holds run_cycles.
REQ-028 run_cycles==0: stay in RUN until host_start.
REQ-029 HALT: core_ready=0, done=1, cycle_count held.
REQ-030 host_start in RUN or HALT: valid command aborts, core_ready=0 next cycle, go LOAD, cycle_count cleared; invalid command -> err, state unchanged.
REQ-031 host_start in LOAD or FLUSH: ignored, err pulse; the load continues undisturbed.
REQ-032 host_valid outside LOAD: ignored, no write.
REQ-033 Index and address arithmetic SHALL never wrap; len<=DEPTH guarantees im_addr<=DEPTH-1.

Reset
REQ-034 rst asserted at any time: state=IDLE immediately; host_ready, im_we, core_ready, busy, done, err =0; im_addr=0, im_wdata=0, cycle_count=0.
REQ-035 Reset mid-LOAD SHALL abandon the session; no im_we after reset assertion.

Structure
REQ-036 State encoding and the DEPTH constant SHALL live in shared package proc_pkg.
REQ-037 Single module; the saturating cycle counter MAY be sub-module sat_counter.

Verification
REQ-038 Load 12 words (host_len=12, run_cycles=180, host_valid held high) -> 12 im_we pulses addr 0..11 in consecutive cycles, FLUSH, core_ready high 180 cycles, then done=1, cycle_count=180.
REQ-039 host_valid toggled every other cycle, len=4 -> exactly 4 writes, addresses 0..3, data matches host order.
REQ-040 host_len=0, then host_len=DEPTH+1 -> err pulses, state stays IDLE, no writes.
REQ-041 host_start during LOAD at word 2 of 5 -> err pulse, all 5 words written, RUN entered.
REQ-042 run_cycles=0, run 70000 cycles -> cycle_count=16'hFFFF, core_ready still 1; host_start len=3 -> core_ready=0 next cycle, LOAD.
REQ-043 rst asserted mid-LOAD (after 3 of 8 words) -> outputs reset immediately, no further im_we, IDLE.
